// File: rtl/yzh_paket.sv
// Opcodes, FSM encoding and shared limits for the accelerator command sequencer.
package yzh_paket;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_FILTRE_RS1 = 3'd1;
  localparam logic [2:0] OP_FILTRE_RS2 = 3'd2;
  localparam logic [2:0] OP_FILTRE_SIL = 3'd3;
  localparam logic [2:0] OP_VERI_RS1   = 3'd4;
  localparam logic [2:0] OP_VERI_RS2   = 3'd5;
  localparam logic [2:0] OP_VERI_SIL   = 3'd6;
  localparam logic [2:0] OP_CONV_RUN   = 3'd7;

  localparam logic [1:0] BOSTA      = 2'd0;
  localparam logic [1:0] CONV_BEKLE = 2'd1;
  localparam logic [1:0] SONUC      = 2'd2;

  localparam logic [5:0] MAX_ELEMAN = 6'd16;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } komut_t;

  // RS2 loads carry two elements, RS1 loads one; one extra bit exposes overflow.
  function automatic logic [5:0] yukle_toplam(input logic [4:0] sayac, input logic [2:0] op);
    return {1'b0, sayac} + (((op == OP_FILTRE_RS2) || (op == OP_VERI_RS2)) ? 6'd2 : 6'd1);
  endfunction

endpackage

// File: rtl/yzh_komut_kuyrugu.sv
// Command FIFO between decode and the sequencer; wrap-bit pointers give full/empty.
module yzh_komut_kuyrugu
  import yzh_paket::*;
#(
  parameter int unsigned DERINLIK = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   yaz_i,
  input  logic   oku_i,
  input  komut_t veri_i,
  output komut_t veri_o,
  output logic   dolu_o,
  output logic   bos_o
);

  localparam int unsigned AW = $clog2(DERINLIK);

  komut_t         mem [DERINLIK];
  logic [AW:0]    yaz_ptr;
  logic [AW:0]    oku_ptr;

  assign bos_o  = (yaz_ptr == oku_ptr);
  assign dolu_o = (yaz_ptr[AW] != oku_ptr[AW]) && (yaz_ptr[AW-1:0] == oku_ptr[AW-1:0]);
  assign veri_o = mem[oku_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
    end else begin
      if (yaz_i && !dolu_o) yaz_ptr <= yaz_ptr + 1'b1;
      if (oku_i && !bos_o)  oku_ptr <= oku_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (yaz_i && !dolu_o) mem[yaz_ptr[AW-1:0]] <= veri_i;
  end

endmodule

// File: rtl/yapay_zeka_denetleyici.sv
// Sequencer that issues queued accelerator commands as registered hzl_* strobes
// and returns conv_run results for writeback.
//   state      | meaning
//   BOSTA      | idle, pops one command per cycle unless frozen
//   CONV_BEKLE | conv request held, waiting for result or timeout
//   SONUC      | result presented until writeback accepts it
module yapay_zeka_denetleyici
  import yzh_paket::*;
#(
  parameter int unsigned KUYRUK_DERINLIK = 4,
  parameter int unsigned ZAMAN_ASIMI     = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        durdur_i,
  input  logic        komut_gecerli_i,
  input  logic [2:0]  komut_op_i,
  input  logic [31:0] komut_rs1_i,
  input  logic [31:0] komut_rs2_i,
  input  logic [4:0]  komut_rd_i,
  output logic        komut_hazir_o,
  output logic        hzl_blok_aktif_o,
  output logic [31:0] hzl_rs1_o,
  output logic [31:0] hzl_rs2_o,
  output logic        hzl_filtre_rs1_en_o,
  output logic        hzl_filtre_rs2_en_o,
  output logic        hzl_filtre_sil_o,
  output logic        hzl_veri_rs1_en_o,
  output logic        hzl_veri_rs2_en_o,
  output logic        hzl_veri_sil_o,
  output logic        hzl_conv_yap_en_o,
  input  logic [31:0] hzl_sonuc_i,
  input  logic        hzl_conv_hazir_i,
  input  logic        hzl_stall_i,
  output logic        sonuc_gecerli_o,
  output logic [31:0] sonuc_o,
  output logic [4:0]  sonuc_rd_o,
  input  logic        sonuc_kabul_i,
  output logic        hata_o,
  output logic        mesgul_o
);

  localparam int unsigned TW = $clog2(ZAMAN_ASIMI + 1);

  komut_t          gelen, bas;
  logic            dolu, bos, push, pop;
  logic [1:0]      durum, durum_d;
  logic [4:0]      filtre_sayac, filtre_d, veri_sayac, veri_d;
  logic [TW-1:0]   zaman, zaman_d;
  logic [5:0]      toplam;
  logic            f1_d, f2_d, fsil_d, v1_d, v2_d, vsil_d, conv_d, hata_d, gecerli_d;
  logic [31:0]     rs1_d, rs2_d, sonuc_d;
  logic [4:0]      rd_d;

  assign gelen         = '{op: komut_op_i, rs1: komut_rs1_i, rs2: komut_rs2_i, rd: komut_rd_i};
  assign push          = komut_gecerli_i && (komut_op_i != OP_NOP) && !dolu;
  assign pop           = (durum == BOSTA) && !durdur_i && !bos;
  assign komut_hazir_o = !dolu;
  assign mesgul_o      = !bos || (durum != BOSTA);

  yzh_komut_kuyrugu #(.DERINLIK(KUYRUK_DERINLIK)) u_kuyruk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .yaz_i  (push),
    .oku_i  (pop),
    .veri_i (gelen),
    .veri_o (bas),
    .dolu_o (dolu),
    .bos_o  (bos)
  );

  always_comb begin
    durum_d   = durum;
    filtre_d  = filtre_sayac;
    veri_d    = veri_sayac;
    zaman_d   = zaman;
    toplam    = 6'd0;
    f1_d      = 1'b0;
    f2_d      = 1'b0;
    fsil_d    = 1'b0;
    v1_d      = 1'b0;
    v2_d      = 1'b0;
    vsil_d    = 1'b0;
    conv_d    = 1'b0;
    hata_d    = 1'b0;
    rs1_d     = hzl_rs1_o;
    rs2_d     = hzl_rs2_o;
    gecerli_d = sonuc_gecerli_o;
    sonuc_d   = sonuc_o;
    rd_d      = sonuc_rd_o;
    case (durum)
      BOSTA: if (pop) begin
        rs1_d = bas.rs1;
        rs2_d = bas.rs2;
        case (bas.op)
          OP_FILTRE_RS1, OP_FILTRE_RS2: begin
            toplam = yukle_toplam(filtre_sayac, bas.op);
            if (toplam > MAX_ELEMAN) hata_d = 1'b1;
            else begin
              filtre_d = toplam[4:0];
              f1_d     = (bas.op == OP_FILTRE_RS1);
              f2_d     = (bas.op == OP_FILTRE_RS2);
            end
          end
          OP_VERI_RS1, OP_VERI_RS2: begin
            toplam = yukle_toplam(veri_sayac, bas.op);
            if (toplam > MAX_ELEMAN) hata_d = 1'b1;
            else begin
              veri_d = toplam[4:0];
              v1_d   = (bas.op == OP_VERI_RS1);
              v2_d   = (bas.op == OP_VERI_RS2);
            end
          end
          OP_FILTRE_SIL: begin
            filtre_d = 5'd0;
            fsil_d   = 1'b1;
          end
          OP_VERI_SIL: begin
            veri_d = 5'd0;
            vsil_d = 1'b1;
          end
          OP_CONV_RUN: begin
            rd_d = bas.rd;
            // An empty matrix never reaches the accelerator.
            if ((filtre_sayac == 5'd0) || (veri_sayac == 5'd0)) begin
              sonuc_d   = 32'd0;
              gecerli_d = 1'b1;
              hata_d    = 1'b1;
              durum_d   = SONUC;
            end else begin
              conv_d  = 1'b1;
              zaman_d = TW'(ZAMAN_ASIMI);
              durum_d = CONV_BEKLE;
            end
          end
          default: ;
        endcase
      end
      CONV_BEKLE: begin
        if (hzl_conv_hazir_i && !hzl_stall_i) begin
          sonuc_d   = hzl_sonuc_i;
          gecerli_d = 1'b1;
          durum_d   = SONUC;
        end else if (!durdur_i && (zaman == TW'(1))) begin
          sonuc_d   = 32'd0;
          gecerli_d = 1'b1;
          hata_d    = 1'b1;
          durum_d   = SONUC;
        end else begin
          conv_d = 1'b1;
          if (!durdur_i) zaman_d = zaman - TW'(1);
        end
      end
      SONUC: if (sonuc_kabul_i) begin
        gecerli_d = 1'b0;
        durum_d   = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum               <= BOSTA;
      filtre_sayac        <= 5'd0;
      veri_sayac          <= 5'd0;
      zaman               <= '0;
      hzl_rs1_o           <= 32'd0;
      hzl_rs2_o           <= 32'd0;
      hzl_filtre_rs1_en_o <= 1'b0;
      hzl_filtre_rs2_en_o <= 1'b0;
      hzl_filtre_sil_o    <= 1'b0;
      hzl_veri_rs1_en_o   <= 1'b0;
      hzl_veri_rs2_en_o   <= 1'b0;
      hzl_veri_sil_o      <= 1'b0;
      hzl_conv_yap_en_o   <= 1'b0;
      hzl_blok_aktif_o    <= 1'b0;
      hata_o              <= 1'b0;
      sonuc_gecerli_o     <= 1'b0;
      sonuc_o             <= 32'd0;
      sonuc_rd_o          <= 5'd0;
    end else begin
      durum               <= durum_d;
      filtre_sayac        <= filtre_d;
      veri_sayac          <= veri_d;
      zaman               <= zaman_d;
      hzl_rs1_o           <= rs1_d;
      hzl_rs2_o           <= rs2_d;
      hzl_filtre_rs1_en_o <= f1_d;
      hzl_filtre_rs2_en_o <= f2_d;
      hzl_filtre_sil_o    <= fsil_d;
      hzl_veri_rs1_en_o   <= v1_d;
      hzl_veri_rs2_en_o   <= v2_d;
      hzl_veri_sil_o      <= vsil_d;
      hzl_conv_yap_en_o   <= conv_d;
      hzl_blok_aktif_o    <= f1_d | f2_d | fsil_d | v1_d | v2_d | vsil_d | conv_d;
      hata_o              <= hata_d;
      sonuc_gecerli_o     <= gecerli_d;
      sonuc_o             <= sonuc_d;
      sonuc_rd_o          <= rd_d;
    end
  end

endmodule
